// File: rtl/adder_share_sequencer.sv
// adder_share_sequencer: one shared 8-bit adder that works byte-serially for two requesters; define ADDER_SUB_EN to add subtraction
module eight_bit_full_adder_module (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] sum_o,
  output logic       cout_o
);
  logic [8:0] c;
  assign c[0] = cin_i;
  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end
  assign cout_o = c[8];
endmodule

module adder_share_sequencer #(
  parameter int  NBYTES = 4,
  localparam int W      = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  input  logic         sub0,
  input  logic         sub1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         busy,
  output logic         done,
  output logic         done_id,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);
  localparam int KW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t         state_q, state_d;
  logic [W-1:0]   a_q, b_q, sum_q;
  logic [KW-1:0]  k_q;
  logic           op_q, carry_q, id_q, last_q, cout_q, ovf_q;
  logic           win, op_win, last_byte, c_byte;
  logic [7:0]     a_byte, b_byte, s_byte;
  assign win       = (req0 & req1) ? ~last_q : req1;
  assign last_byte = k_q == KW'(NBYTES - 1);
  assign a_byte    = a_q[8*k_q +: 8];
`ifdef ADDER_SUB_EN
  assign op_win = win ? sub1 : sub0;
  assign b_byte = b_q[8*k_q +: 8] ^ {8{op_q}};
`else
  logic unused_sub;
  assign unused_sub = sub0 | sub1;
  assign op_win     = 1'b0;
  assign b_byte     = b_q[8*k_q +: 8];
`endif
  eight_bit_full_adder_module u_add (
    .a_i   (a_byte),
    .b_i   (b_byte),
    .cin_i (carry_q),
    .sum_o (s_byte),
    .cout_o(c_byte)
  );
  // state register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end
  // next state: arbitrate in IDLE, walk the bytes in BUSY, single DONE cycle
  always_comb begin
    state_d = state_q == IDLE ? ((req0 | req1) ? BUSY : IDLE) :
              state_q == BUSY ? (last_byte ? DONE : BUSY) : IDLE;
  end
  // outputs decoded from state; grant shows during the first byte cycle
  always_comb begin
    busy = state_q != IDLE;
    done = state_q == DONE;
    gnt0 = state_q == BUSY && k_q == '0 && !id_q;
    gnt1 = state_q == BUSY && k_q == '0 && id_q;
  end
  // operand capture on grant, then one result byte and carry per cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      k_q     <= '0;
      op_q    <= 1'b0;
      carry_q <= 1'b0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (state_q == IDLE && (req0 | req1)) begin
      a_q     <= win ? a1 : a0;
      b_q     <= win ? b1 : b0;
      op_q    <= op_win;
      carry_q <= op_win;
      sum_q   <= '0;
      k_q     <= '0;
      id_q    <= win;
      last_q  <= win;
    end else if (state_q == BUSY) begin
      sum_q[8*k_q +: 8] <= s_byte;
      carry_q           <= c_byte;
      k_q               <= last_byte ? '0 : k_q + 1'b1;
      if (last_byte) begin
        cout_q <= c_byte;
        ovf_q  <= (a_byte[7] == b_byte[7]) && (s_byte[7] != a_byte[7]);
      end
    end
  end
  assign sum     = sum_q;
  assign cout    = cout_q;
  assign ovf     = ovf_q;
  assign done_id = id_q;
endmodule

// File: tb/tb_adder_share_sequencer.sv
// tb_adder_share_sequencer: directed checks of arbitration, timing, carry/overflow, subtract and reset abort
module tb_adder_share_sequencer;
  localparam int NB = 4;
  localparam int W  = 32;
  logic         clk = 0, reset_n = 0, req0 = 0, req1 = 0, sub0 = 0, sub1 = 0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         gnt0, gnt1, busy, done, done_id, cout, ovf;
  logic [W-1:0] sum;
  int           total = 0, bad = 0;
  always #5 clk = ~clk;
  adder_share_sequencer #(.NBYTES(NB)) dut (
    .clk(clk), .reset_n(reset_n), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .sub0(sub0), .sub1(sub1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .done_id(done_id),
    .sum(sum), .cout(cout), .ovf(ovf)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic run_op(input bit c, input logic [31:0] a, input logic [31:0] b, input bit s,
                        input logic [31:0] es, input bit ec, input bit eo, input string tag);
    int n;
    @(negedge clk);
    if (c) begin req1 = 1; a1 = a; b1 = b; sub1 = s; end
    else   begin req0 = 1; a0 = a; b0 = b; sub0 = s; end
    @(negedge clk);
    chk({tag, ".gnt"}, {gnt1, gnt0}, c ? 2'b10 : 2'b01);
    chk({tag, ".busy"}, busy, 1);
    req0 = 0; req1 = 0;
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom; sub0 = !s; sub1 = !s;
    n = 0;
    while (!done && n < 20) begin @(negedge clk); n++; end
    chk({tag, ".lat"}, n, NB);
    chk({tag, ".sum"}, sum, es);
    chk({tag, ".cout"}, cout, ec);
    chk({tag, ".ovf"}, ovf, eo);
    chk({tag, ".id"}, done_id, c);
  endtask
  initial begin
    int n, m, extra;
    repeat (3) @(negedge clk);
    chk("rst.ctl", {gnt0, gnt1, busy, done, done_id, cout, ovf}, 0);
    chk("rst.sum", sum, 0);
    reset_n = 1;
    run_op(0, 32'h0000_00FF, 32'h0000_0001, 0, 32'h0000_0100, 0, 0, "t1");
    run_op(1, 32'hFFFF_FFFF, 32'h0000_0001, 0, 32'h0000_0000, 1, 0, "t2a");
    run_op(1, 32'h7FFF_FFFF, 32'h0000_0001, 0, 32'h8000_0000, 0, 1, "t2b");
`ifdef ADDER_SUB_EN
    run_op(0, 32'h0000_0005, 32'h0000_0007, 1, 32'hFFFF_FFFE, 0, 0, "t4a");
    run_op(0, 32'h8000_0000, 32'h0000_0001, 1, 32'h7FFF_FFFF, 1, 1, "t4b");
`else
    run_op(0, 32'h0000_0005, 32'h0000_0007, 1, 32'h0000_000C, 0, 0, "t4a");
    run_op(0, 32'h8000_0000, 32'h0000_0001, 1, 32'h8000_0001, 0, 0, "t4b");
`endif
    @(negedge clk);
    req0 = 1; a0 = 32'h1234_5678; b0 = 32'h1111_1111; sub0 = 0; sub1 = 0;
    @(negedge clk);
    chk("t5.gnt", gnt0, 1);
    req0 = 0;
    @(negedge clk);
    reset_n = 0;
    @(negedge clk);
    chk("t5.ctl", {gnt0, gnt1, busy, done, done_id, cout, ovf}, 0);
    chk("t5.sum", sum, 0);
    reset_n = 1;
    n = 0;
    repeat (8) begin @(negedge clk); if (done || busy) n++; end
    chk("t5.nodone", n, 0);
    run_op(0, 32'h0102_0304, 32'h00FF_00FF, 0, 32'h0201_0403, 0, 0, "t5b");
    @(negedge clk);
    reset_n = 0;
    @(negedge clk);
    reset_n = 1;
    req0 = 1; req1 = 1;
    a0 = 32'h0102_0304; b0 = 32'h1020_3040; a1 = 32'hF000_0000; b1 = 32'h2000_0000;
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!(gnt0 | gnt1) && n < 20) begin @(negedge clk); n++; end
      chk("t3.gap", n, i == 0 ? 1 : 2);
      chk("t3.gnt", {gnt1, gnt0}, (i % 2) ? 2'b10 : 2'b01);
      @(negedge clk);
      chk("t3.pulse", {gnt1, gnt0}, 0);
      m = 0;
      while (!done && m < 20) begin
        if (gnt0 | gnt1) extra++;
        @(negedge clk);
        m++;
      end
      chk("t3.id", done_id, i % 2);
      chk("t3.sum", sum, (i % 2) ? 32'h1000_0000 : 32'h1122_3344);
      chk("t3.cout", cout, i % 2);
    end
    req0 = 0; req1 = 0;
    chk("t3.extra", extra, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
